// File: rtl/aib_tx_framer.sv
// AIB TX framer: input FIFO feeding an IDLE/TRAIN/MARK/DATA serialiser for the IO buffer data0/data1 pins.
// Optional macro AIB_TX_PRBS_EN replaces the fixed TRAIN pattern with PRBS7.
module aib_tx_framer #(
  parameter int unsigned DW         = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          i_tx_clk,
  input  logic          i_rst_n,
  input  logic          c_tx_en,
  input  logic          c_ddr_mode,
  input  logic [7:0]    c_train_len,
  input  logic          i_train_req,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic          o_tx_data0,
  output logic          o_tx_data1,
  output logic [1:0]    o_state,
  output logic          o_busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned KW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_MARK  = 2'd2,
    ST_DATA  = 2'd3
  } state_e;

  logic [1:0]    rst_sync_q, rst_sync_d;
  logic          rst_n_int;
  state_e        state_q, state_d;
  logic          pend_q, pend_d;
  logic          ddr_q, ddr_d;
  logic [DW-1:0] sh_q, sh_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic          d0_q, d0_d, d1_q, d1_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [DW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          push, pop;
  logic [DW-1:0] head;
  logic [KW-1:0] cyc_per_word;
  logic [7:0]    len_eff;
  logic          trn_ddr, trn_b0, trn_b1;

  assign rst_n_int    = rst_sync_q[1];
  assign o_ready      = rst_n_int & c_tx_en & (count_q != CW'(FIFO_DEPTH));
  assign push         = i_valid & o_ready;
  assign head         = mem_q[rd_ptr_q];
  assign cyc_per_word = ddr_q ? KW'(DW / 2) : KW'(DW);
  assign len_eff      = (c_train_len == 8'd0) ? 8'd1 : c_train_len;
  assign trn_ddr      = (state_q == ST_TRAIN) ? ddr_q : c_ddr_mode;

`ifdef AIB_TX_PRBS_EN
  logic [6:0] lfsr_q, lfsr_d, trn_src, trn_s1, trn_s2, trn_next;

  function automatic logic [6:0] prbs_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  // Seed is reloaded for the first TRAIN cycle, so the sequence restarts per burst.
  always_comb begin
    trn_src  = (state_q == ST_TRAIN) ? lfsr_q : 7'h7F;
    trn_s1   = prbs_step(trn_src);
    trn_s2   = prbs_step(trn_s1);
    trn_b0   = trn_s1[0];
    trn_b1   = trn_ddr ? trn_s2[0] : trn_s1[0];
    trn_next = trn_ddr ? trn_s2 : trn_s1;
  end
`else
  assign trn_b0 = 1'b1;
  assign trn_b1 = 1'b0;
`endif

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    state_d    = state_q;
    pend_d     = pend_q | (i_train_req & c_tx_en);
    ddr_d      = ddr_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    d0_d       = 1'b0;
    d1_d       = 1'b0;
    pop        = 1'b0;
`ifdef AIB_TX_PRBS_EN
    lfsr_d     = lfsr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_TRAIN;
          pend_d  = 1'b0;
          tcnt_d  = 8'd1;
          ddr_d   = c_ddr_mode;
          d0_d    = trn_b0;
          d1_d    = trn_b1;
`ifdef AIB_TX_PRBS_EN
          lfsr_d  = trn_next;
`endif
        end else if (count_q != '0) begin
          state_d = ST_MARK;
          ddr_d   = c_ddr_mode;
          d0_d    = 1'b1;
          d1_d    = 1'b1;
        end
      end
      ST_TRAIN: begin
        if (tcnt_q >= len_eff) begin
          state_d = ST_IDLE;
          tcnt_d  = 8'd0;
        end else begin
          tcnt_d  = tcnt_q + 8'd1;
          d0_d    = trn_b0;
          d1_d    = trn_b1;
`ifdef AIB_TX_PRBS_EN
          lfsr_d  = trn_next;
`endif
        end
      end
      ST_MARK, ST_DATA: begin
        // MARK exit and every word boundary share the pop-and-emit path.
        if (state_q == ST_MARK || cnt_q == cyc_per_word) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = ST_DATA;
            d0_d    = head[0];
            d1_d    = ddr_q ? head[1] : head[0];
            sh_d    = ddr_q ? (head >> 2) : (head >> 1);
            cnt_d   = KW'(1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          d0_d  = sh_q[0];
          d1_d  = ddr_q ? sh_q[1] : sh_q[0];
          sh_d  = ddr_q ? (sh_q >> 2) : (sh_q >> 1);
          cnt_d = cnt_q + KW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!c_tx_en) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
      d0_d    = 1'b0;
      d1_d    = 1'b0;
      pop     = 1'b0;
      sh_d    = '0;
      cnt_d   = '0;
      tcnt_d  = 8'd0;
    end

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = i_data;
    if (!c_tx_en) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
    end

    busy_d = (state_d != ST_IDLE) || (count_d != '0);
  end

  always_ff @(posedge i_tx_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  always_ff @(posedge i_tx_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q  <= ST_IDLE;
      pend_q   <= 1'b0;
      ddr_q    <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
      tcnt_q   <= 8'd0;
      d0_q     <= 1'b0;
      d1_q     <= 1'b0;
      busy_q   <= 1'b0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef AIB_TX_PRBS_EN
      lfsr_q   <= 7'h7F;
`endif
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      ddr_q    <= ddr_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      d0_q     <= d0_d;
      d1_q     <= d1_d;
      busy_q   <= busy_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef AIB_TX_PRBS_EN
      lfsr_q   <= lfsr_d;
`endif
    end
  end

  assign o_tx_data0 = d0_q;
  assign o_tx_data1 = d1_q;
  assign o_state    = state_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_aib_tx_framer.sv
// Scoreboard bench for aib_tx_framer: directed bursts queue expected {state,data0,data1}; a monitor checks every non-IDLE cycle.
module tb_aib_tx_framer;

  logic       i_tx_clk = 1'b0;
  logic       i_rst_n;
  logic       c_tx_en;
  logic       c_ddr_mode;
  logic [7:0] c_train_len;
  logic       i_train_req;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready, o_tx_data0, o_tx_data1, o_busy;
  logic [1:0] o_state;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [3:0]  exp_q[$];

  aib_tx_framer #(.DW(8), .FIFO_DEPTH(4)) dut (
    .i_tx_clk   (i_tx_clk),
    .i_rst_n    (i_rst_n),
    .c_tx_en    (c_tx_en),
    .c_ddr_mode (c_ddr_mode),
    .c_train_len(c_train_len),
    .i_train_req(i_train_req),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_tx_data0 (o_tx_data0),
    .o_tx_data1 (o_tx_data1),
    .o_state    (o_state),
    .o_busy     (o_busy)
  );

  always #5 i_tx_clk = ~i_tx_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every non-IDLE cycle must match the next queued expectation.
  always @(negedge i_tx_clk) begin
    if (o_state != 2'd0) begin
      if (exp_q.size() == 0) chk("stream_extra", {28'd0, o_state, o_tx_data0, o_tx_data1}, 32'd0);
      else chk("stream", {28'd0, o_state, o_tx_data0, o_tx_data1}, {28'd0, exp_q.pop_front()});
    end
  end

  task automatic exp_mark();
    exp_q.push_back(4'b10_11);
  endtask

  task automatic exp_word(input logic [7:0] w, input logic ddr);
    if (ddr) for (int k = 0; k < 4; k++) exp_q.push_back({2'd3, w[2*k], w[2*k+1]});
    else     for (int k = 0; k < 8; k++) exp_q.push_back({2'd3, w[k], w[k]});
  endtask

  task automatic exp_train(input int n, input logic ddr);
`ifdef AIB_TX_PRBS_EN
    logic [6:0] s = 7'h7F;
    logic b0, b1;
    for (int i = 0; i < n; i++) begin
      b0 = s[6] ^ s[5]; s = {s[5:0], b0};
      b1 = b0;
      if (ddr) begin b1 = s[6] ^ s[5]; s = {s[5:0], b1}; end
      exp_q.push_back({2'd1, b0, b1});
    end
`else
    for (int i = 0; i < n; i++) exp_q.push_back({2'd1, 1'b1, 1'b0});
    if (ddr) begin end
`endif
  endtask

  task automatic send1(input logic [7:0] w);
    @(negedge i_tx_clk);
    i_data = w; i_valid = 1'b1;
    @(negedge i_tx_clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    while (!(o_state == 2'd0 && !o_busy && exp_q.size() == 0) && n < 300) begin
      @(negedge i_tx_clk);
      n++;
    end
    chk({name, "_timeout"}, n < 300, 1);
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic wait_state(input logic [1:0] st);
    int unsigned n = 0;
    while (o_state != st && n < 100) begin
      @(negedge i_tx_clk);
      n++;
    end
    chk("wait_state_timeout", n < 100, 1);
  endtask

  logic [7:0] words [6];
  int  idx, guard;
  logic r, seen_full;

  initial begin
    i_rst_n = 1'b0; c_tx_en = 1'b1; c_ddr_mode = 1'b1; c_train_len = 8'd3;
    i_train_req = 1'b0; i_data = '0; i_valid = 1'b0;
    words = '{8'h11, 8'h22, 8'h3C, 8'hC3, 8'h5A, 8'hE7};

    // Reset state and two-flop release
    #12;
    chk("rst_state", o_state, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_data", {o_tx_data0, o_tx_data1}, 0);
    @(negedge i_tx_clk); i_rst_n = 1'b1;
    @(negedge i_tx_clk); chk("rel_ready_edge1", o_ready, 0);
    @(negedge i_tx_clk); chk("rel_ready_edge2", o_ready, 1);

    // DDR 8'hB4 with latency checks
    c_ddr_mode = 1'b1;
    exp_mark();
    exp_q.push_back(4'b11_00); exp_q.push_back(4'b11_10);
    exp_q.push_back(4'b11_11); exp_q.push_back(4'b11_01);
    send1(8'hB4);
    chk("lat_idle_after_push", o_state, 0);
    chk("lat_busy_after_push", o_busy, 1);
    @(negedge i_tx_clk); chk("lat_mark_edge1", o_state, 2);
    wait_idle("ddr_b4");
    chk("ddr_b4_idle_out", {o_tx_data0, o_tx_data1}, 0);

    // SDR 8'h81
    c_ddr_mode = 1'b0;
    exp_mark();
    exp_q.push_back(4'b11_11);
    for (int k = 0; k < 6; k++) exp_q.push_back(4'b11_00);
    exp_q.push_back(4'b11_11);
    send1(8'h81);
    wait_idle("sdr_81");

    // Fill FIFO during a long TRAIN: ready drops at 4, then one MARK and 6 back-to-back words
    c_ddr_mode = 1'b1; c_train_len = 8'd10;
    exp_train(10, 1'b1);
    exp_mark();
    for (int k = 0; k < 6; k++) exp_word(words[k], 1'b1);
    @(negedge i_tx_clk);
    i_train_req = 1'b1;
    idx = 0; guard = 0; seen_full = 1'b0;
    while (idx < 6 && guard < 300) begin
      i_data = words[idx]; i_valid = 1'b1;
      if (idx == 4 && !seen_full) begin
        chk("full_ready", o_ready, 0);
        seen_full = 1'b1;
      end
      r = o_ready;
      @(posedge i_tx_clk);
      if (r) idx++;
      @(negedge i_tx_clk);
      i_train_req = 1'b0;
      guard++;
    end
    i_valid = 1'b0;
    chk("fill_accepts", idx, 6);
    wait_idle("fill6");

    // Train request during DATA waits for the burst, then len 3; then len 0 -> 1 cycle
    c_ddr_mode = 1'b0; c_train_len = 8'd3;
    exp_mark(); exp_word(8'h3C, 1'b0); exp_train(3, 1'b0);
    send1(8'h3C);
    wait_state(2'd3);
    i_train_req = 1'b1;
    @(negedge i_tx_clk); i_train_req = 1'b0;
    wait_idle("train3");
    c_train_len = 8'd0;
    exp_train(1, 1'b0);
    @(negedge i_tx_clk); i_train_req = 1'b1;
    @(negedge i_tx_clk); i_train_req = 1'b0;
    wait_idle("train0");

    // Disable mid-word with a second word queued
    c_ddr_mode = 1'b1;
    exp_mark(); exp_q.push_back({2'd3, 1'b1, 1'b0}); exp_q.push_back({2'd3, 1'b0, 1'b1});
    @(negedge i_tx_clk); i_data = 8'h99; i_valid = 1'b1;
    @(negedge i_tx_clk); i_data = 8'h66;
    @(negedge i_tx_clk); i_valid = 1'b0;
    @(negedge i_tx_clk);
    @(negedge i_tx_clk); c_tx_en = 1'b0;
    @(negedge i_tx_clk);
    chk("dis_state", o_state, 0);
    chk("dis_data", {o_tx_data0, o_tx_data1}, 0);
    chk("dis_busy", o_busy, 0);
    chk("dis_ready", o_ready, 0);
    chk("dis_drain", exp_q.size(), 0);
    c_tx_en = 1'b1;
    #1 chk("reen_ready", o_ready, 1);
    exp_mark(); exp_word(8'h5A, 1'b1);
    send1(8'h5A);
    wait_idle("reenable");

    // Asynchronous reset during DATA
    exp_mark(); exp_q.push_back(4'b11_11);
    send1(8'hFF);
    @(negedge i_tx_clk);
    @(negedge i_tx_clk);
    #1 i_rst_n = 1'b0;
    #1;
    chk("arst_state", o_state, 0);
    chk("arst_data", {o_tx_data0, o_tx_data1}, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_ready", o_ready, 0);
    @(negedge i_tx_clk); i_rst_n = 1'b1;
    repeat (4) @(negedge i_tx_clk);
    chk("final_state", o_state, 0);
    chk("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aib_tx_framer.md
AIB_TX_FRAMER -- requirements
Module: aib_tx_framer

Interface
REQ-001 Parameter DW, default 8, meaning data word width; even, range 2..16.
REQ-002 Parameter FIFO_DEPTH, default 4, meaning input FIFO entries; power of two.
REQ-003 i_tx_clk  in  1  TX clock, shared with the IO buffer TX path; all logic rises on posedge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low; clock is i_tx_clk.
REQ-005 c_tx_en  in  1  block enable.
REQ-006 c_ddr_mode  in  1  1 = two bits per cycle; 0 = one bit per cycle.
REQ-007 c_train_len  in  8  number of TRAIN cycles; 0 is treated as 1.
REQ-008 i_train_req  in  1  single-cycle request to send a training burst.
REQ-009 i_data  in  DW  word to transmit.
REQ-010 i_valid  in  1  i_data valid.
REQ-011 o_ready  out  1  FIFO can accept a word.
REQ-012 o_tx_data0  out  1  bit driven while i_tx_clk is low (IO buffer data0).
REQ-013 o_tx_data1  out  1  bit driven while i_tx_clk is high (IO buffer data1).
REQ-014 o_state  out  2  FSM state: IDLE=0, TRAIN=1, MARK=2, DATA=3.
REQ-015 o_busy  out  1  1 when o_state != IDLE or the FIFO is non-empty.

Function
REQ-016 The FSM shall have four states, IDLE, TRAIN, MARK and DATA, and all outputs except o_ready shall be registered.
REQ-017 FIFO push shall occur on i_valid & o_ready, and o_ready = c_tx_en & !full, computed from the current FIFO count only (no push while full, even if a pop occurs in the same cycle).
REQ-018 IDLE: the block shall drive 0/0; at each edge a pending train request shall take priority -> TRAIN, else a non-empty FIFO -> MARK.
REQ-019 A train request shall be latched into a pending flag whenever i_train_req=1 and c_tx_en=1; the flag shall be cleared on entry to TRAIN, and requests outside IDLE shall wait until the FSM returns to IDLE.
REQ-020 TRAIN shall last exactly max(c_train_len,1) cycles and drive data0=1, data1=0, then return to IDLE.
REQ-021 MARK shall last one cycle and drive data0=1, data1=1; c_ddr_mode shall be sampled on MARK entry and held through the burst.
REQ-022 DATA shall pop one word at each word boundary and shift it LSB first; in DDR, cycle k drives data0=bit 2k and data1=bit 2k+1 (DW/2 cycles per word); in SDR, data0=data1=bit k (DW cycles per word).
REQ-023 Words shall be sent back to back with no gap; if the FIFO is empty at a word boundary the FSM shall go to IDLE, and the next burst shall start again with MARK.
REQ-024 Latency: for a word accepted at edge 0 into an empty FIFO in IDLE, MARK appears after edge 1 and data bits 0/1 appear after edge 2.
REQ-025 If c_tx_en=0 at an edge in any state: the FSM shall go to IDLE, the FIFO and pending flag shall be flushed, outputs shall be 0/0, and a partial word shall be discarded.

Reset
REQ-026 On assertion of i_rst_n=0 the block shall asynchronously set: FSM=IDLE, FIFO empty, pending flag=0, counters=0, o_tx_data0=0, o_tx_data1=0, o_state=0, o_busy=0, o_ready=0.
REQ-027 Reset release shall be synchronous to i_tx_clk through a two-flop deassertion synchronizer, and the first state change shall occur no earlier than the third edge after release.

Configuration
REQ-028 Macro AIB_TX_PRBS_EN: when defined, TRAIN shall drive PRBS7 (x^7+x^6+1, seed 7'h7F reloaded at TRAIN entry), with two consecutive bits per cycle (data0 first) in DDR mode and one bit on both outputs in SDR mode.
REQ-029 When AIB_TX_PRBS_EN is undefined, TRAIN shall drive the fixed 1/0 pattern and no PRBS logic shall be present.

Verification
REQ-030 DDR, DW=8, c_tx_en=1, push 8'hB4 -> outputs 0/0, then 1/1, then data0/data1 pairs 0/0, 1/0, 1/1, 0/1, then 0/0.
REQ-031 SDR, push 8'h81 -> MARK, then 8 cycles with both outputs equal to 1,0,0,0,0,0,0,1, then IDLE.
REQ-032 Hold i_valid=1 for 6 words with no pops -> o_ready drops after 4 accepts, all 6 words are transmitted back to back after a single MARK, and no word is lost or duplicated.
REQ-033 c_train_len=3, i_train_req pulsed during DATA -> the burst completes, then exactly 3 TRAIN cycles of 1/0 (PRBS with the macro), then IDLE; c_train_len=0 -> 1 TRAIN cycle.
REQ-034 c_tx_en dropped in the middle of a word -> next edge IDLE with 0/0, FIFO empty, o_busy=0; re-enable and push -> a clean MARK-led burst.
REQ-035 i_rst_n asserted during DATA -> all outputs are 0 immediately, without waiting for a clock edge.
